// File: rtl/riscv_pkg.sv
// Shared RISC-V write-back definitions: data widths, load funct3 encodings
// and the write-back request record used by the arbiter skid FIFO.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    // Sign- or zero-extend a byte to XLEN
    function automatic logic [XLEN-1:0] ext8(input logic [7:0] b, input logic sgn);
        ext8 = {{(XLEN-8){sgn & b[7]}}, b};
    endfunction

    // Sign- or zero-extend a halfword to XLEN
    function automatic logic [XLEN-1:0] ext16(input logic [15:0] h, input logic sgn);
        ext16 = {{(XLEN-16){sgn & h[15]}}, h};
    endfunction

endpackage

// File: rtl/wb_arbiter_load_align.sv
// Load data alignment: picks the addressed byte/halfword out of the raw
// memory word, extends it, and flags misaligned or reserved encodings.
module load_align
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] raw_word,
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    output logic [XLEN-1:0] data,
    output logic            misalign
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = raw_word[{off, 3'b000} +: 8];
    assign half_s = off[1] ? raw_word[31:16] : raw_word[15:0];

    // Decode funct3 into extracted data and a misalignment flag
    always_comb begin
        data     = {XLEN{1'b0}};
        misalign = 1'b0;
        case (funct3)
            F3_LB: begin
                data = ext8(byte_s, 1'b1);
            end
            F3_LBU: begin
                data = ext8(byte_s, 1'b0);
            end
            F3_LH: begin
                data     = ext16(half_s, 1'b1);
                misalign = off[0];
            end
            F3_LHU: begin
                data     = ext16(half_s, 1'b0);
                misalign = off[0];
            end
            F3_LW: begin
                data     = raw_word;
                misalign = (off != 2'b00);
            end
            default: begin
                data     = {XLEN{1'b0}};
                misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: merges load responses and ALU results onto
// the single write port, buffers ALU results that lose arbitration in a small
// skid FIFO, and tracks outstanding loads per register for decode stalls.
module wb_arbiter
    import riscv_pkg::*;
#(
    parameter int ALU_BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              ld_issue,
    input  logic [REG_AW-1:0] ld_issue_rd,
    input  logic              ld_valid,
    input  logic [REG_AW-1:0] ld_rd,
    input  logic [XLEN-1:0]   ld_data,
    input  logic [2:0]        ld_funct3,
    input  logic [1:0]        ld_off,
    output logic              ld_misalign,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata
);

    localparam int PW = (ALU_BUF_DEPTH > 1) ? $clog2(ALU_BUF_DEPTH) : 1;
    localparam int CW = PW + 1;

    // Skid FIFO state
    wb_req_t         fifo_mem_r [ALU_BUF_DEPTH];
    logic [PW-1:0]   fifo_wr_ptr_r;
    logic [PW-1:0]   fifo_rd_ptr_r;
    logic [CW-1:0]   fifo_cnt_r;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic            fifo_push_s;
    logic            fifo_pop_s;

    // Arbitration
    logic [XLEN-1:0] ld_aligned_s;
    logic            ld_mis_s;
    logic            ld_write_s;
    logic            alu_fire_s;
    logic            win_valid_s;
    wb_req_t         win_req_s;

    // Scoreboard
    logic [XLEN-1:0] pending_r;
    logic [XLEN-1:0] pending_nxt_s;
    logic            fifo_hit1_s;
    logic            fifo_hit2_s;

    load_align u_load_align (
        .raw_word (ld_data),
        .funct3   (ld_funct3),
        .off      (ld_off),
        .data     (ld_aligned_s),
        .misalign (ld_mis_s)
    );

    assign fifo_full_s  = (fifo_cnt_r == CW'(ALU_BUF_DEPTH));
    assign fifo_empty_s = (fifo_cnt_r == {CW{1'b0}});
    assign alu_ready    = !fifo_full_s;
    assign alu_fire_s   = alu_valid & alu_ready;
    // A misaligned beat writes nothing, so it leaves the slot to ALU/FIFO traffic
    assign ld_write_s   = ld_valid & !ld_mis_s;

    // Pick the single writer for this cycle: load > FIFO head > incoming ALU
    always_comb begin
        win_valid_s = 1'b0;
        win_req_s   = '{rd: {REG_AW{1'b0}}, data: {XLEN{1'b0}}};
        fifo_pop_s  = 1'b0;
        fifo_push_s = 1'b0;
        if (ld_write_s) begin
            win_valid_s = 1'b1;
            win_req_s   = '{rd: ld_rd, data: ld_aligned_s};
            fifo_push_s = alu_fire_s;
        end else if (!fifo_empty_s) begin
            win_valid_s = 1'b1;
            win_req_s   = fifo_mem_r[fifo_rd_ptr_r];
            fifo_pop_s  = 1'b1;
            fifo_push_s = alu_fire_s;
        end else if (alu_fire_s) begin
            win_valid_s = 1'b1;
            win_req_s   = '{rd: alu_rd, data: alu_data};
        end else begin
            win_valid_s = 1'b0;
        end
    end

    // FIFO storage writes; validity is tracked by pointers and count only
    always_ff @(posedge clk) begin
        if (fifo_push_s) begin
            fifo_mem_r[fifo_wr_ptr_r] <= '{rd: alu_rd, data: alu_data};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wr_ptr_r <= {PW{1'b0}};
            fifo_rd_ptr_r <= {PW{1'b0}};
            fifo_cnt_r    <= {CW{1'b0}};
        end else begin
            if (fifo_push_s) begin
                fifo_wr_ptr_r <= fifo_wr_ptr_r + PW'(1);
            end
            if (fifo_pop_s) begin
                fifo_rd_ptr_r <= fifo_rd_ptr_r + PW'(1);
            end
            case ({fifo_push_s, fifo_pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CW'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CW'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Registered write port and misalign pulse; x0 consumes the slot silently
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we       <= 1'b0;
            rf_waddr    <= {REG_AW{1'b0}};
            rf_wdata    <= {XLEN{1'b0}};
            ld_misalign <= 1'b0;
        end else begin
            rf_we       <= win_valid_s & (win_req_s.rd != {REG_AW{1'b0}});
            ld_misalign <= ld_valid & ld_mis_s;
            if (win_valid_s) begin
                rf_waddr <= win_req_s.rd;
                rf_wdata <= win_req_s.data;
            end
        end
    end

    // Next pending vector: beat clears, issue sets, and set wins on a tie
    always_comb begin
        pending_nxt_s = pending_r;
        if (ld_valid) begin
            pending_nxt_s[ld_rd] = 1'b0;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
        if (ld_issue && (ld_issue_rd != {REG_AW{1'b0}})) begin
            pending_nxt_s[ld_issue_rd] = 1'b1;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
    end

    // Load-pending scoreboard register
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= {XLEN{1'b0}};
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    // Search the live FIFO entries for either decode source register
    always_comb begin
        logic [PW-1:0] idx;
        fifo_hit1_s = 1'b0;
        fifo_hit2_s = 1'b0;
        idx         = fifo_rd_ptr_r;
        for (int i = 0; i < ALU_BUF_DEPTH; i++) begin
            idx = fifo_rd_ptr_r + PW'(i);
            if (CW'(i) < fifo_cnt_r) begin
                fifo_hit1_s = fifo_hit1_s | (fifo_mem_r[idx].rd == rs1_addr);
                fifo_hit2_s = fifo_hit2_s | (fifo_mem_r[idx].rd == rs2_addr);
            end else begin
                fifo_hit1_s = fifo_hit1_s;
                fifo_hit2_s = fifo_hit2_s;
            end
        end
    end

    // Decode stall: register not yet in the RF, never for x0
    always_comb begin
        rs1_busy = (rs1_addr != {REG_AW{1'b0}}) &
                   (pending_r[rs1_addr] | (rf_we & (rf_waddr == rs1_addr)) | fifo_hit1_s);
        rs2_busy = (rs2_addr != {REG_AW{1'b0}}) &
                   (pending_r[rs2_addr] | (rf_we & (rf_waddr == rs2_addr)) | fifo_hit2_s);
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter.
module tb_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_off;
    logic        ld_misalign;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int n_assert;
    int n_fail;

    wb_arbiter #(.ALU_BUF_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_issue    (ld_issue),
        .ld_issue_rd (ld_issue_rd),
        .ld_valid    (ld_valid),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .ld_funct3   (ld_funct3),
        .ld_off      (ld_off),
        .ld_misalign (ld_misalign),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
        check({tag, "_we"}, {31'd0, rf_we}, 32'd1);
        check({tag, "_addr"}, {27'd0, rf_waddr}, {27'd0, a});
        check({tag, "_data"}, rf_wdata, d);
    endtask

    task automatic ld_beat(input logic [4:0] rd, input logic [31:0] d,
                           input logic [2:0] f3, input logic [1:0] off);
        ld_valid  = 1'b1;
        ld_rd     = rd;
        ld_data   = d;
        ld_funct3 = f3;
        ld_off    = off;
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        alu_valid   = 1'b0;
        alu_rd      = 5'd0;
        alu_data    = 32'h0;
        ld_issue    = 1'b0;
        ld_issue_rd = 5'd0;
        ld_valid    = 1'b0;
        ld_rd       = 5'd0;
        ld_data     = 32'h0;
        ld_funct3   = 3'b010;
        ld_off      = 2'd0;
        rs1_addr    = 5'd0;
        rs2_addr    = 5'd0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_we", {31'd0, rf_we}, 32'd0);
        check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
        check("rst_wdata", rf_wdata, 32'h0);
        check("rst_mis", {31'd0, ld_misalign}, 32'd0);
        check("rst_ready", {31'd0, alu_ready}, 32'd1);
        rs1_addr = 5'd5;
        #1;
        check("rst_busy", {31'd0, rs1_busy}, 32'd0);

        // 1: ALU bypass
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        alu_valid = 1'b0;
        expect_wr("alu_only", 5'd5, 32'hDEADBEEF);
        tick();
        check("alu_idle_we", {31'd0, rf_we}, 32'd0);

        // 2: collision, FIFO fill, order preserved
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h00000033;
        ld_beat(5'd4, 32'h00000044, 3'b010, 2'd0);
        tick();
        expect_wr("col_ld4", 5'd4, 32'h00000044);
        alu_rd = 5'd10; alu_data = 32'h000000A0;
        ld_beat(5'd20, 32'h20202020, 3'b010, 2'd0);
        tick();
        expect_wr("col_ld20", 5'd20, 32'h20202020);
        check("fifo_full_ready", {31'd0, alu_ready}, 32'd0);
        rs2_addr = 5'd10;
        #1;
        check("fifo_hit_busy", {31'd0, rs2_busy}, 32'd1);
        alu_rd = 5'd11; alu_data = 32'h000000B1;
        ld_beat(5'd21, 32'h21212121, 3'b010, 2'd0);
        tick();
        expect_wr("col_ld21", 5'd21, 32'h21212121);
        check("still_full", {31'd0, alu_ready}, 32'd0);
        ld_valid = 1'b0;
        tick();
        expect_wr("fifo_x3", 5'd3, 32'h00000033);
        check("ready_again", {31'd0, alu_ready}, 32'd1);
        tick();
        alu_valid = 1'b0;
        expect_wr("fifo_x10", 5'd10, 32'h000000A0);
        tick();
        expect_wr("fifo_x11", 5'd11, 32'h000000B1);
        tick();
        check("drained_we", {31'd0, rf_we}, 32'd0);
        rs2_addr = 5'd0;

        // 3: extraction and extension
        ld_beat(5'd12, 32'h80FF7F01, 3'b000, 2'd1);
        tick();
        expect_wr("lb_off1", 5'd12, 32'h0000007F);
        ld_beat(5'd12, 32'h80FF7F01, 3'b000, 2'd2);
        tick();
        expect_wr("lb_off2", 5'd12, 32'hFFFFFFFF);
        ld_beat(5'd12, 32'h80FF7F01, 3'b001, 2'd2);
        tick();
        expect_wr("lh_off2", 5'd12, 32'hFFFF80FF);
        ld_beat(5'd12, 32'h80FF7F01, 3'b101, 2'd2);
        tick();
        expect_wr("lhu_off2", 5'd12, 32'h000080FF);
        ld_beat(5'd12, 32'h80FF7F01, 3'b010, 2'd0);
        tick();
        expect_wr("lw_off0", 5'd12, 32'h80FF7F01);
        ld_beat(5'd12, 32'h80FF7F01, 3'b100, 2'd3);
        tick();
        expect_wr("lbu_off3", 5'd12, 32'h00000080);
        ld_valid = 1'b0;
        tick();

        // 4: scoreboard
        ld_issue = 1'b1; ld_issue_rd = 5'd7;
        tick();
        ld_issue = 1'b0;
        rs1_addr = 5'd7;
        #1;
        check("sb_pending", {31'd0, rs1_busy}, 32'd1);
        ld_beat(5'd7, 32'h00000077, 3'b010, 2'd0);
        #1;
        check("sb_beat_cycle", {31'd0, rs1_busy}, 32'd1);
        tick();
        ld_valid = 1'b0;
        expect_wr("sb_wr7", 5'd7, 32'h00000077);
        check("sb_inflight", {31'd0, rs1_busy}, 32'd1);
        tick();
        check("sb_cleared", {31'd0, rs1_busy}, 32'd0);
        ld_issue = 1'b1; ld_issue_rd = 5'd7;
        ld_beat(5'd7, 32'h00000078, 3'b010, 2'd0);
        tick();
        ld_issue = 1'b0; ld_valid = 1'b0;
        tick();
        check("sb_set_wins", {31'd0, rs1_busy}, 32'd1);
        ld_beat(5'd7, 32'h00000079, 3'b010, 2'd0);
        tick();
        ld_valid = 1'b0;
        tick();
        check("sb_final_clear", {31'd0, rs1_busy}, 32'd0);

        // 5: misaligned load gives its slot to the ALU; x0 writes suppressed
        ld_issue = 1'b1; ld_issue_rd = 5'd13;
        tick();
        ld_issue = 1'b0;
        ld_beat(5'd13, 32'h13131313, 3'b010, 2'd2);
        alu_valid = 1'b1; alu_rd = 5'd14; alu_data = 32'h0000000E;
        tick();
        ld_valid = 1'b0; alu_valid = 1'b0;
        expect_wr("mis_alu_slot", 5'd14, 32'h0000000E);
        check("mis_pulse", {31'd0, ld_misalign}, 32'd1);
        rs1_addr = 5'd13;
        #1;
        check("mis_pend_clr", {31'd0, rs1_busy}, 32'd0);
        tick();
        check("mis_pulse_end", {31'd0, ld_misalign}, 32'd0);
        check("mis_no_we", {31'd0, rf_we}, 32'd0);
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h00001234;
        ld_issue = 1'b1; ld_issue_rd = 5'd0;
        tick();
        alu_valid = 1'b0; ld_issue = 1'b0;
        check("x0_no_we", {31'd0, rf_we}, 32'd0);
        rs1_addr = 5'd0;
        #1;
        check("x0_never_busy", {31'd0, rs1_busy}, 32'd0);

        // 6: reset mid-operation
        alu_valid = 1'b1; alu_rd = 5'd15; alu_data = 32'h00000015;
        ld_beat(5'd16, 32'h00000016, 3'b010, 2'd0);
        ld_issue = 1'b1; ld_issue_rd = 5'd9;
        tick();
        ld_issue = 1'b0;
        alu_rd = 5'd17; alu_data = 32'h00000017;
        ld_beat(5'd18, 32'h00000018, 3'b010, 2'd0);
        tick();
        alu_valid = 1'b0; ld_valid = 1'b0;
        check("pre_rst_full", {31'd0, alu_ready}, 32'd0);
        rs1_addr = 5'd9;
        rs2_addr = 5'd15;
        #1;
        check("pre_rst_x9", {31'd0, rs1_busy}, 32'd1);
        check("pre_rst_x15", {31'd0, rs2_busy}, 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_we", {31'd0, rf_we}, 32'd0);
        check("mid_rst_waddr", {27'd0, rf_waddr}, 32'd0);
        check("mid_rst_wdata", rf_wdata, 32'h0);
        check("mid_rst_mis", {31'd0, ld_misalign}, 32'd0);
        check("mid_rst_ready", {31'd0, alu_ready}, 32'd1);
        check("mid_rst_x9", {31'd0, rs1_busy}, 32'd0);
        check("mid_rst_x15", {31'd0, rs2_busy}, 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_we1", {31'd0, rf_we}, 32'd0);
        tick();
        check("post_rst_we2", {31'd0, rf_we}, 32'd0);
        check("post_rst_ready", {31'd0, alu_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
